// File: rtl/clock_pkg.sv
// Shared types and helpers for the multi-alarm clock: slot states, BCD field
// widths, load validation and a modulo-60 BCD incrementer.
package clock_pkg;

  localparam int H_W = 6;
  localparam int M_W = 7;
  localparam int S_W = 7;

  typedef enum logic [1:0] {
    IDLE,
    RINGING,
    SNOOZED
  } slot_state_t;

  function automatic logic bcd_time_ok(input logic [H_W-1:0] h, input logic [M_W-1:0] m);
    logic h_ok;
    logic m_ok;
    h_ok = (h[3:0] <= 4'd9) &&
           ((h[5:4] < 2'd2) || ((h[5:4] == 2'd2) && (h[3:0] <= 4'd3)));
    m_ok = (m[3:0] <= 4'd9) && (m[6:4] <= 3'd5);
    return h_ok && m_ok;
  endfunction

  // Result is {carry_out, next_value}; carry set on the 59 -> 00 wrap.
  function automatic logic [7:0] bcd_inc60(input logic [6:0] v);
    if (v[3:0] != 4'd9)
      return {1'b0, v[6:4], v[3:0] + 4'd1};
    else if (v[6:4] != 3'd5)
      return {1'b0, v[6:4] + 3'd1, 4'd0};
    else
      return {1'b1, 7'd0};
  endfunction

endpackage

// File: rtl/alarm_slot.sv
// One alarm slot: programmed HH:MM, enable bit and the IDLE/RINGING/SNOOZED
// state machine with its snooze-countdown and ring-duration counters.
module alarm_slot
  import clock_pkg::*;
#(
  parameter int SNOOZE_S = 300,
  parameter int RING_S   = 60
) (
  input  logic           clk,
  input  logic           i_rst_n,
  input  logic           i_tick,
  input  logic [H_W-1:0] i_h,
  input  logic [M_W-1:0] i_m,
  input  logic [S_W-1:0] i_s,
  input  logic           i_ld,
  input  logic [H_W-1:0] i_ld_h,
  input  logic [M_W-1:0] i_ld_m,
  input  logic           i_en_we,
  input  logic           i_en_val,
  input  logic           i_snooze,
  input  logic           i_stop,
  output logic           o_ringing
);

  localparam logic [11:0] SNZ_INIT  = 12'(SNOOZE_S);
  localparam logic [7:0]  RING_LAST = 8'(RING_S - 1);

  slot_state_t    r_state;
  logic           r_en;
  logic [H_W-1:0] r_alm_h;
  logic [M_W-1:0] r_alm_m;
  logic [11:0]    r_snz_cnt;
  logic [7:0]     r_ring_cnt;

  logic w_match;
  logic w_force_idle;

  // i_h/i_m/i_s carry the time as it will read after this tick.
  assign w_match      = r_en && i_tick && (i_h == r_alm_h) && (i_m == r_alm_m) && (i_s == '0);
  assign w_force_idle = i_ld | (i_en_we & ~i_en_val);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_en       <= 1'b0;
      r_alm_h    <= '0;
      r_alm_m    <= '0;
      r_snz_cnt  <= '0;
      r_ring_cnt <= '0;
    end else begin
      if (i_en_we) r_en <= i_en_val;
      if (i_ld) begin
        r_alm_h <= i_ld_h;
        r_alm_m <= i_ld_m;
      end
      if (w_force_idle) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_match) begin
              r_state    <= RINGING;
              r_ring_cnt <= '0;
            end
          end
          RINGING: begin
            if (i_stop) begin
              r_state <= IDLE;
            end else if (i_snooze) begin
              r_state   <= SNOOZED;
              r_snz_cnt <= SNZ_INIT;
            end else if (i_tick) begin
              if (r_ring_cnt == RING_LAST) r_state <= IDLE;
              else r_ring_cnt <= r_ring_cnt + 8'd1;
            end
          end
          SNOOZED: begin
            if (i_stop) begin
              r_state <= IDLE;
            end else if (i_tick) begin
              if (r_snz_cnt == 12'd1) begin
                r_state    <= RINGING;
                r_ring_cnt <= '0;
              end else begin
                r_snz_cnt <= r_snz_cnt - 12'd1;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_ringing = (r_state == RINGING);

endmodule

// File: rtl/multi_alarm_clock.sv
// 24-hour BCD clock with a per-second divider, load validation and
// NUM_ALARMS alarm slots merged onto one alarm line by a priority encoder.
module multi_alarm_clock
  import clock_pkg::*;
#(
  parameter int CLK_DIV    = 10,
  parameter int NUM_ALARMS = 4,
  parameter int SNOOZE_S   = 300,
  parameter int RING_S     = 60,
  localparam int SEL_W     = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [H_W-1:0]   h_in,
  input  logic [M_W-1:0]   m_in,
  input  logic             ld_time,
  input  logic             ld_alarm,
  input  logic [SEL_W-1:0] alarm_sel,
  input  logic             al_en_we,
  input  logic             al_en_val,
  input  logic             snooze,
  input  logic             stop,
  output logic [H_W-1:0]   h_out,
  output logic [M_W-1:0]   m_out,
  output logic [S_W-1:0]   s_out,
  output logic             sec_tick,
  output logic             alarm,
  output logic [SEL_W-1:0] alarm_id,
  output logic             ld_err
);

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_tick;
  logic             r_ld_err;
  logic [H_W-1:0]   r_h;
  logic [M_W-1:0]   r_m;
  logic [S_W-1:0]   r_s;

  logic [DIV_W-1:0]      w_div_next;
  logic                  w_ld_ok;
  logic                  w_ld_time_ok;
  logic                  w_slot_tick;
  logic [7:0]            w_s_step;
  logic [7:0]            w_m_step;
  logic [H_W-1:0]        w_h_inc;
  logic [NUM_ALARMS-1:0] w_ringing;
  logic [SEL_W-1:0]      w_alarm_id;

  assign w_ld_ok      = bcd_time_ok(h_in, m_in);
  assign w_ld_time_ok = ld_time & w_ld_ok;
  // A valid time load swallows a coincident tick, so slots never see it.
  assign w_slot_tick  = r_tick & ~w_ld_time_ok;
  assign w_div_next   = (w_ld_time_ok || (r_div == DIV_LAST)) ? '0 : r_div + 1'b1;

  always_comb begin
    w_s_step = bcd_inc60(r_s);
    w_m_step = w_s_step[7] ? bcd_inc60(r_m) : {1'b0, r_m};
    w_h_inc  = r_h;
    if (w_m_step[7]) begin
      if (r_h == 6'h23)         w_h_inc = '0;
      else if (r_h[3:0] == 4'd9) w_h_inc = {r_h[5:4] + 2'd1, 4'd0};
      else                       w_h_inc = {r_h[5:4], r_h[3:0] + 4'd1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div    <= '0;
      r_tick   <= 1'b0;
      r_ld_err <= 1'b0;
      r_h      <= '0;
      r_m      <= '0;
      r_s      <= '0;
    end else begin
      r_div    <= w_div_next;
      r_tick   <= (w_div_next == DIV_LAST);
      r_ld_err <= (ld_time | ld_alarm) & ~w_ld_ok;
      if (w_ld_time_ok) begin
        r_h <= h_in;
        r_m <= m_in;
        r_s <= '0;
      end else if (r_tick) begin
        r_h <= w_h_inc;
        r_m <= w_m_step[6:0];
        r_s <= w_s_step[6:0];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_slot
      alarm_slot #(
        .SNOOZE_S (SNOOZE_S),
        .RING_S   (RING_S)
      ) u_slot (
        .clk       (clk),
        .i_rst_n   (reset),
        .i_tick    (w_slot_tick),
        .i_h       (w_h_inc),
        .i_m       (w_m_step[6:0]),
        .i_s       (w_s_step[6:0]),
        .i_ld      (ld_alarm & w_ld_ok & (alarm_sel == SEL_W'(gi))),
        .i_ld_h    (h_in),
        .i_ld_m    (m_in),
        .i_en_we   (al_en_we & (alarm_sel == SEL_W'(gi))),
        .i_en_val  (al_en_val),
        .i_snooze  (snooze),
        .i_stop    (stop),
        .o_ringing (w_ringing[gi])
      );
    end
  endgenerate

  always_comb begin
    w_alarm_id = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (w_ringing[i]) w_alarm_id = SEL_W'(i);
    end
  end

  assign alarm    = |w_ringing;
  assign alarm_id = w_alarm_id;
  assign h_out    = r_h;
  assign m_out    = r_m;
  assign s_out    = r_s;
  assign sec_tick = r_tick;
  assign ld_err   = r_ld_err;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed plus randomized bench; time is modelled as seconds-of-day and each
// slot by its alarm second, ring age and snooze remainder.
module tb_multi_alarm_clock;

  localparam int CLK_DIV = 4;
  localparam int NA      = 4;
  localparam int SNZ     = 3;
  localparam int RING    = 5;
  localparam int S_IDLE  = 0;
  localparam int S_RING  = 1;
  localparam int S_SNZ   = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] h_in;
  logic [6:0] m_in;
  logic       ld_time, ld_alarm, al_en_we, al_en_val, snooze, stop;
  logic [1:0] alarm_sel;
  logic [5:0] h_out;
  logic [6:0] m_out, s_out;
  logic       sec_tick, alarm, ld_err;
  logic [1:0] alarm_id;

  int n_vec = 0;
  int n_err = 0;

  int m_sod, m_div;
  bit m_err;
  bit m_en [NA];
  int m_at [NA];
  int m_mode [NA];
  int m_age [NA];
  int m_left [NA];

  multi_alarm_clock #(
    .CLK_DIV    (CLK_DIV),
    .NUM_ALARMS (NA),
    .SNOOZE_S   (SNZ),
    .RING_S     (RING)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .h_in      (h_in),
    .m_in      (m_in),
    .ld_time   (ld_time),
    .ld_alarm  (ld_alarm),
    .alarm_sel (alarm_sel),
    .al_en_we  (al_en_we),
    .al_en_val (al_en_val),
    .snooze    (snooze),
    .stop      (stop),
    .h_out     (h_out),
    .m_out     (m_out),
    .s_out     (s_out),
    .sec_tick  (sec_tick),
    .alarm     (alarm),
    .alarm_id  (alarm_id),
    .ld_err    (ld_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_sod = 0;
    m_div = 0;
    m_err = 1'b0;
    for (int k = 0; k < NA; k++) begin
      m_en[k] = 1'b0; m_at[k] = 0; m_mode[k] = S_IDLE; m_age[k] = 0; m_left[k] = 0;
    end
  endtask

  // One clock edge: advance the model from current inputs, then compare.
  task automatic cyc();
    int  hv, mv, exp_id;
    bit  valid, tick, teff, sel_k, old_en, exp_al;
    hv = int'(h_in[5:4]) * 10 + int'(h_in[3:0]);
    mv = int'(m_in[6:4]) * 10 + int'(m_in[3:0]);
    valid = (int'(h_in[3:0]) <= 9) && (int'(m_in[3:0]) <= 9) && (hv < 24) && (mv < 60);
    tick  = (m_div == CLK_DIV - 1);
    teff  = tick;
    m_err = (ld_time || ld_alarm) && !valid;
    if (ld_time && valid) begin
      m_sod = hv * 3600 + mv * 60;
      m_div = 0;
      teff  = 1'b0;
    end else begin
      m_div = (m_div + 1) % CLK_DIV;
      if (tick) m_sod = (m_sod + 1) % 86400;
    end
    for (int k = 0; k < NA; k++) begin
      sel_k  = (int'(alarm_sel) == k);
      old_en = m_en[k];
      if (al_en_we && sel_k) m_en[k] = al_en_val;
      if (ld_alarm && valid && sel_k) m_at[k] = hv * 3600 + mv * 60;
      if ((ld_alarm && valid && sel_k) || (al_en_we && sel_k && !al_en_val)) begin
        m_mode[k] = S_IDLE;
      end else if (m_mode[k] == S_IDLE) begin
        if (old_en && teff && m_sod == m_at[k]) begin m_mode[k] = S_RING; m_age[k] = 0; end
      end else if (m_mode[k] == S_RING) begin
        if (stop) m_mode[k] = S_IDLE;
        else if (snooze) begin m_mode[k] = S_SNZ; m_left[k] = SNZ; end
        else if (teff) begin
          m_age[k]++;
          if (m_age[k] == RING) m_mode[k] = S_IDLE;
        end
      end else begin
        if (stop) m_mode[k] = S_IDLE;
        else if (teff) begin
          m_left[k]--;
          if (m_left[k] == 0) begin m_mode[k] = S_RING; m_age[k] = 0; end
        end
      end
    end
    exp_al = 1'b0;
    exp_id = 0;
    for (int k = NA - 1; k >= 0; k--) begin
      if (m_mode[k] == S_RING) begin exp_al = 1'b1; exp_id = k; end
    end
    @(posedge clk);
    #1;
    chk("h_out", 32'(h_out), 32'(bcd(m_sod / 3600)));
    chk("m_out", 32'(m_out), 32'(bcd((m_sod / 60) % 60)));
    chk("s_out", 32'(s_out), 32'(bcd(m_sod % 60)));
    chk("sec_tick", 32'(sec_tick), 32'(m_div == CLK_DIV - 1));
    chk("alarm", 32'(alarm), 32'(exp_al));
    chk("alarm_id", 32'(alarm_id), 32'(exp_id));
    chk("ld_err", 32'(ld_err), 32'(m_err));
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic load_time(input logic [5:0] h, input logic [6:0] m);
    h_in = h; m_in = m; ld_time = 1'b1;
    cyc();
    ld_time = 1'b0;
  endtask

  task automatic en_slot(input logic [1:0] s, input bit en);
    alarm_sel = s; al_en_val = en; al_en_we = 1'b1;
    cyc();
    al_en_we = 1'b0;
  endtask

  task automatic prog_slot(input logic [1:0] s, input logic [5:0] h, input logic [6:0] m, input bit en);
    alarm_sel = s; h_in = h; m_in = m; ld_alarm = 1'b1;
    cyc();
    ld_alarm = 1'b0;
    en_slot(s, en);
  endtask

  task automatic wait_alarm(input int budget);
    for (int i = 0; i < budget && alarm !== 1'b1; i++) cyc();
    chk("wait_alarm", 32'(alarm), 32'd1);
  endtask

  initial begin
    int last, gap, ticks, r, nm;
    reset = 1'b0;
    h_in = '0; m_in = '0; ld_time = 0; ld_alarm = 0; alarm_sel = '0;
    al_en_we = 0; al_en_val = 0; snooze = 0; stop = 0;
    model_reset();
    #2;
    chk("rst_h", 32'(h_out), 32'd0);
    chk("rst_alarm", 32'(alarm), 32'd0);
    chk("rst_tick", 32'(sec_tick), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    run(6);

    // Midnight rollover and tick spacing.
    load_time(6'h23, 7'h59);
    run(240);
    chk("roll_h", 32'(h_out), 32'h00);
    chk("roll_m", 32'(m_out), 32'h00);
    chk("roll_s", 32'(s_out), 32'h00);
    last = -1; gap = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (sec_tick === 1'b1) begin
        if (last >= 0) gap = i - last;
        last = i;
      end
    end
    chk("tick_period", 32'(gap), 32'd4);

    // Single slot rings at its minute and auto-stops after RING seconds.
    prog_slot(2'd2, 6'h07, 7'h30, 1'b1);
    load_time(6'h07, 7'h29);
    wait_alarm(300);
    chk("ring2_id", 32'(alarm_id), 32'd2);
    chk("ring2_m", 32'(m_out), 32'h30);
    chk("ring2_s", 32'(s_out), 32'h00);
    run(19);
    chk("ring2_still", 32'(alarm), 32'd1);
    run(1);
    chk("ring2_off", 32'(alarm), 32'd0);
    chk("ring2_off_s", 32'(s_out), 32'h05);
    en_slot(2'd2, 1'b0);

    // Two slots at once: lowest index wins, stop silences both.
    prog_slot(2'd1, 6'h06, 7'h00, 1'b1);
    prog_slot(2'd3, 6'h06, 7'h00, 1'b1);
    load_time(6'h05, 7'h59);
    wait_alarm(300);
    chk("dual_id", 32'(alarm_id), 32'd1);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("stop_alarm", 32'(alarm), 32'd0);
    run(8);
    en_slot(2'd1, 1'b0);
    en_slot(2'd3, 1'b0);

    // Snooze re-rings after exactly SNZ ticks.
    prog_slot(2'd0, 6'h08, 7'h00, 1'b1);
    load_time(6'h07, 7'h59);
    wait_alarm(300);
    snooze = 1'b1; cyc(); snooze = 1'b0;
    chk("snooze_off", 32'(alarm), 32'd0);
    ticks = 0;
    for (int i = 0; i < 40 && alarm !== 1'b1; i++) begin
      if (sec_tick === 1'b1) ticks++;
      cyc();
    end
    chk("snooze_ticks", 32'(ticks), 32'd3);
    chk("snooze_rering", 32'(alarm), 32'd1);
    stop = 1'b1; cyc(); stop = 1'b0;
    en_slot(2'd0, 1'b0);

    // Rejected loads and a load landing on a tick.
    load_time(6'h24, 7'h10);
    chk("err_h24", 32'(ld_err), 32'd1);
    cyc();
    chk("err_pulse", 32'(ld_err), 32'd0);
    load_time(6'h12, 7'h6A);
    chk("err_m6a", 32'(ld_err), 32'd1);
    h_in = 6'h1C; m_in = 7'h00; ld_time = 1'b1; ld_alarm = 1'b1; alarm_sel = 2'd1;
    cyc();
    ld_time = 1'b0; ld_alarm = 1'b0;
    chk("err_both", 32'(ld_err), 32'd1);
    cyc();
    for (int i = 0; i < 8 && sec_tick !== 1'b1; i++) cyc();
    chk("tick_seen", 32'(sec_tick), 32'd1);
    load_time(6'h12, 7'h34);
    chk("coinc_h", 32'(h_out), 32'h12);
    chk("coinc_m", 32'(m_out), 32'h34);
    chk("coinc_s", 32'(s_out), 32'h00);
    run(2);
    chk("coinc_div0", 32'(sec_tick), 32'd0);
    run(1);
    chk("coinc_div3", 32'(sec_tick), 32'd1);

    // A disabled slot at the current time stays quiet.
    prog_slot(2'd3, 6'h09, 7'h00, 1'b0);
    load_time(6'h08, 7'h59);
    run(250);
    chk("disabled_quiet", 32'(alarm), 32'd0);

    // Asynchronous reset in the middle of a ring.
    prog_slot(2'd0, 6'h10, 7'h00, 1'b1);
    load_time(6'h09, 7'h59);
    wait_alarm(300);
    run(2);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_alarm", 32'(alarm), 32'd0);
    chk("arst_id", 32'(alarm_id), 32'd0);
    chk("arst_h", 32'(h_out), 32'd0);
    chk("arst_m", 32'(m_out), 32'd0);
    chk("arst_s", 32'(s_out), 32'd0);
    chk("arst_tick", 32'(sec_tick), 32'd0);
    chk("arst_err", 32'(ld_err), 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    run(3);

    // Randomized traffic against the model.
    load_time(6'h13, 7'h00);
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 199);
      ld_time = 0; ld_alarm = 0; al_en_we = 0; snooze = 0; stop = 0;
      alarm_sel = 2'($urandom_range(0, 3));
      if (r < 2) begin
        ld_time = 1'b1;
        ld_alarm = (r == 0);
        h_in = 6'($urandom_range(0, 63));
        m_in = 7'($urandom_range(0, 127));
      end else if (r < 10) begin
        nm = (m_sod / 60 + 1) % 1440;
        ld_alarm = 1'b1;
        h_in = 6'(bcd(nm / 60));
        m_in = 7'(bcd(nm % 60));
        if (r == 9) m_in = 7'($urandom_range(0, 127));
      end else if (r < 18) begin
        al_en_we = 1'b1;
        al_en_val = ($urandom_range(0, 3) != 0);
      end else if (r < 24) begin
        snooze = 1'b1;
      end else if (r < 27) begin
        stop = 1'b1;
        snooze = ($urandom_range(0, 1) == 1);
      end
      cyc();
    end
    ld_time = 0; ld_alarm = 0; al_en_we = 0; snooze = 0; stop = 0;
    run(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
